// File: rtl/wb_stage_ctrl_if.sv
// -----------------------------------------------------------------------------
// wb_stage_ctrl_if
// Bundle between the M/W pipeline boundary and the write-back stage.
//   master : drives the M-stage capture inputs and stall/flush, observes W.
//   slave  : the write-back stage itself.
// Signals
//   stall, flush        pipeline control for the W register
//   m_valid .. m_addr_lo M-stage instruction, PC, ALU result, DM word, addr[1:0]
//   w_valid, w_instr, w_pc  current W contents
//   grf_we, grf_wa, grf_wd  GRF write port
//   w_misalign          W holds a misaligned load
//   retire_cnt          retired-instruction counter
// -----------------------------------------------------------------------------
interface wb_stage_ctrl_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
);
    logic              stall;
    logic              flush;
    logic              m_valid;
    logic [31:0]       m_instr;
    logic [XLEN-1:0]   m_pc;
    logic [XLEN-1:0]   m_alu;
    logic [XLEN-1:0]   m_dmrd;
    logic [1:0]        m_addr_lo;

    logic              w_valid;
    logic [31:0]       w_instr;
    logic [XLEN-1:0]   w_pc;
    logic              grf_we;
    logic [REG_AW-1:0] grf_wa;
    logic [XLEN-1:0]   grf_wd;
    logic              w_misalign;
    logic [CNT_W-1:0]  retire_cnt;

    modport master (
        output stall, flush, m_valid, m_instr, m_pc, m_alu, m_dmrd, m_addr_lo,
        input  w_valid, w_instr, w_pc, grf_we, grf_wa, grf_wd, w_misalign, retire_cnt
    );

    modport slave (
        input  stall, flush, m_valid, m_instr, m_pc, m_alu, m_dmrd, m_addr_lo,
        output w_valid, w_instr, w_pc, grf_we, grf_wa, grf_wd, w_misalign, retire_cnt
    );
endinterface

// File: rtl/wb_stage_ctrl.sv
// -----------------------------------------------------------------------------
// wb_stage_ctrl
// Write-back stage of the pipelined MIPS core: the W pipeline register plus
// GRF write control. Captures the M-stage instruction, PC, ALU result and raw
// DM word, then decodes GRF write enable/address/data, extracts sub-word
// loads, flags misaligned loads and counts retired instructions.
// Ports
//   clk    core clock, rising edge
//   reset  asynchronous, active-high
//   bus    wb_stage_ctrl_if.slave (see interface for signal list)
// -----------------------------------------------------------------------------
module wb_stage_ctrl #(
    parameter int XLEN        = 32,
    parameter int REG_AW      = 5,
    parameter int LINK_REG    = 31,
    parameter int LINK_OFFSET = 8,
    parameter int CNT_W       = 32
) (
    input  logic            clk,
    input  logic            reset,
    wb_stage_ctrl_if.slave  bus
);
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;

    logic              valid_q;
    logic [31:0]       instr_q;
    logic [XLEN-1:0]   pc_q;
    logic [XLEN-1:0]   alu_q;
    logic [XLEN-1:0]   dmrd_q;
    logic [1:0]        lo_q;
    logic [CNT_W-1:0]  cnt_q;

    // W register and retire counter. The instruction in W retires whenever
    // W is replaced, which includes a flush issued during a stall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
            alu_q   <= '0;
            dmrd_q  <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
        end else begin
            if (bus.flush) begin
                valid_q <= 1'b0;
                instr_q <= '0;
            end else if (!bus.stall) begin
                valid_q <= bus.m_valid;
                instr_q <= bus.m_valid ? bus.m_instr : 32'h0;
                pc_q    <= bus.m_pc;
                alu_q   <= bus.m_alu;
                dmrd_q  <= bus.m_dmrd;
                lo_q    <= bus.m_addr_lo;
            end
            if (valid_q && (!bus.stall || bus.flush))
                cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    logic [5:0]        op;
    logic [5:0]        fun;
    logic              wr_rd;
    logic              wr_rt;
    logic              is_jal;
    logic              is_jalr;
    logic              is_load;
    logic              misalign;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [XLEN-1:0]   load_val;
    logic [REG_AW-1:0] wa_dec;
    logic [XLEN-1:0]   wd_dec;
    logic              writes;

    assign op  = instr_q[31:26];
    assign fun = instr_q[5:0];

    always_comb begin
        wr_rd   = 1'b0;
        wr_rt   = 1'b0;
        is_jal  = 1'b0;
        is_jalr = 1'b0;
        is_load = 1'b0;
        case (op)
            OP_RTYPE: begin
                case (fun)
                    6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                    6'h10, 6'h12,
                    6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                    6'h2a, 6'h2b: wr_rd = 1'b1;
                    6'h09:        is_jalr = 1'b1;
                    default:      ;
                endcase
            end
            OP_JAL: is_jal = 1'b1;
            6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f: wr_rt = 1'b1;
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: is_load = 1'b1;
            default: ;
        endcase
    end

    assign misalign = valid_q &&
                      (((op == OP_LW) && (lo_q != 2'b00)) ||
                       (((op == OP_LH) || (op == OP_LHU)) && lo_q[0]));

    // DM word is little-endian: byte k lives at bits [8k+7:8k].
    assign byte_sel = dmrd_q[8*lo_q +: 8];
    assign half_sel = dmrd_q[16*lo_q[1] +: 16];

    always_comb begin
        load_val = dmrd_q;
        case (op)
            OP_LB:   load_val = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            OP_LBU:  load_val = {{(XLEN-8){1'b0}}, byte_sel};
            OP_LH:   load_val = {{(XLEN-16){half_sel[15]}}, half_sel};
            OP_LHU:  load_val = {{(XLEN-16){1'b0}}, half_sel};
            default: load_val = dmrd_q;
        endcase
    end

    always_comb begin
        wa_dec = '0;
        wd_dec = alu_q;
        if (wr_rd || is_jalr)
            wa_dec = instr_q[15:11];
        else if (wr_rt || is_load)
            wa_dec = instr_q[20:16];
        else if (is_jal)
            wa_dec = REG_AW'(LINK_REG);

        if (is_jal || is_jalr)
            wd_dec = pc_q + XLEN'(LINK_OFFSET);
        else if (is_load)
            wd_dec = load_val;
    end

    assign writes = wr_rd || wr_rt || is_jal || is_jalr || is_load;

    assign bus.w_valid    = valid_q;
    assign bus.w_instr    = instr_q;
    assign bus.w_pc       = pc_q;
    assign bus.w_misalign = misalign;
    assign bus.grf_wa     = valid_q ? wa_dec : '0;
    assign bus.grf_wd     = valid_q ? wd_dec : '0;
    assign bus.grf_we     = valid_q && writes && (wa_dec != '0) && !misalign;
    assign bus.retire_cnt = cnt_q;
endmodule
